// File: rtl/adder_mon_pkg.sv
// adder_mon_pkg
// Shared definitions for the adder scoreboard monitor.
//   res_width()   : result width for a given operand width (carry bit included);
//                   used by the monitor to build its result type.
//   DEF_WIDTH     : default operand width.
//   RES_W         : result width at the default operand width.
//   OVF/UNF/FIRST : bit positions inside the sticky-flag vector.
package adder_mon_pkg;

  localparam int DEF_WIDTH = 4;

  // A sum of two WIDTH-bit operands needs one extra bit for the carry.
  function automatic int res_width(input int width);
    return width + 1;
  endfunction

  localparam int RES_W = res_width(DEF_WIDTH);

  // Sticky-flag vector layout.
  localparam int OVF    = 0;
  localparam int UNF    = 1;
  localparam int FIRST  = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/mon_sync_fifo.sv
// mon_sync_fifo
// Single-clock FIFO holding the expected results, in order.
// Ports:
//   clk, rst      : clock; synchronous active-high reset (empties the queue)
//   push, wdata   : request to write wdata at the tail
//   pop           : request to remove the head
//   rdata         : current head (valid while empty is low)
//   full, empty   : occupancy status before this cycle's push/pop
//   count         : number of stored entries
// A pop on an empty queue is ignored. A push while full is accepted only when
// a pop happens in the same cycle; otherwise it is dropped.
module mon_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/adder_scoreboard_monitor.sv
// adder_scoreboard_monitor
// Passive scoreboard beside the adder. Every accepted operand pair queues its
// expected sum; every DUT result is compared with the oldest queued sum.
// Ports:
//   clk, rst              : clock; synchronous active-high reset (wins over clear)
//   in_valid, a, b        : DUT accepted operands this cycle
//   out_valid, c          : DUT result this cycle
//   clear                 : zero counters, sticky flags and capture registers
//   pass_cnt, fail_cnt    : saturating match / mismatch counters
//   pending               : queued expected results
//   overflow, underflow   : sticky protocol flags
//   err_valid/exp/act     : one-cycle mismatch pulse with the values compared
//   first_valid/exp/act   : first mismatch since reset or clear
// Handshake: in_valid and out_valid are qualifiers only. Each is sampled on
// one rising edge and means one transaction; there is no ready, and the
// monitor never stalls the DUT.
module adder_scoreboard_monitor
  import adder_mon_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       out_valid,
  input  logic [WIDTH:0]             c,
  input  logic                       clear,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       err_valid,
  output logic [WIDTH:0]             err_exp,
  output logic [WIDTH:0]             err_act,
  output logic [WIDTH:0]             first_exp,
  output logic [WIDTH:0]             first_act,
  output logic                       first_valid
);

  localparam int RW = res_width(WIDTH);
  typedef logic [RW-1:0] res_t;

  res_t              exp_sum;
  res_t              head;
  logic              full;
  logic              empty;
  logic              do_pop;
  logic              push_dropped;
  logic              mismatch;
  logic [FLAG_W-1:0] flags;

  // Zero-extend both operands so the carry lands in the top bit.
  assign exp_sum = {1'b0, a} + {1'b0, b};

  mon_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (exp_sum),
    .pop   (out_valid),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // Emptiness is judged before this cycle's push, so a same-cycle push is
  // never compared against the result arriving with it.
  assign do_pop       = out_valid && !empty;
  assign push_dropped = in_valid && full && !do_pop;
  assign mismatch     = do_pop && (head != c);

  assign overflow    = flags[OVF];
  assign underflow   = flags[UNF];
  assign first_valid = flags[FIRST];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      flags     <= '0;
      err_valid <= 1'b0;
      err_exp   <= '0;
      err_act   <= '0;
      first_exp <= '0;
      first_act <= '0;
    end else begin
      err_valid <= 1'b0;
      if (push_dropped)         flags[OVF] <= 1'b1;
      if (out_valid && empty)   flags[UNF] <= 1'b1;
      if (do_pop) begin
        if (mismatch) begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          err_valid <= 1'b1;
          err_exp   <= head;
          err_act   <= c;
          if (!flags[FIRST]) begin
            flags[FIRST] <= 1'b1;
            first_exp    <= head;
            first_act    <= c;
          end
        end else begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end
      end
    end
  end

endmodule
